wb_master_bridge: RTL and testbench

//  Parametrised successor to the single-outstanding CPU-to-Wishbone master.

---
 rtl/wb_bridge_pkg.sv | 30 +++
 rtl/wb_wbuf_fifo.sv | 54 +++++
 rtl/wb_master_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_wb_master_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the CPU-to-Wishbone master bridge.
//   wb_state_e   : bus FSM states (IDLE / WR_CYC / RD_CYC)
//   wbuf_entry_t : posted-write entry layout {adr, dat, sel} at the default widths.
//                  The top re-declares the same layout at its own AW/DW.
//   clog2        : ceiling log2 for sizing pointers and counters
package wb_bridge_pkg;

  localparam int WB_AW = 26;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_CYC = 2'd1,
    RD_CYC = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
    logic [WB_DW/8-1:0] sel;
  } wbuf_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Posted-write FIFO for the Wishbone bridge.
//   clk_i, rst_i : clock, async active-low reset (flushes pointers and count)
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dout         : head entry, valid while !empty
//   full, empty  : occupancy flags
// Pointers are log2(DEPTH) bits and wrap naturally; count is one bit wider.
module wb_wbuf_fifo
  import wb_bridge_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/wb_master_bridge.sv
// CPU-to-Wishbone classic master with posted-write buffer.
//   CPU side : req_valid_i/req_ready_o handshake (req_we_i, req_adr_i, req_dat_i, req_sel_i),
//              rsp_valid_o pulse with rsp_dat_o/rsp_err_o for reads,
//              sticky wr_err_o for failed posted writes, cleared by wr_err_clr_i.
//   Bus side : adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, tagn_o (all registered),
//              dat_i, ack_i, err_i.
//   clk_i, rst_i : clock, async active-low reset.
// Writes are buffered in wb_wbuf_fifo; a read waits in a holding register and
// blocks further requests, so it always follows every earlier write on the bus.
// Optional macro WB_TIMEOUT_EN: ends a cycle as an error after TMO_CYCLES
// cycles without ack/err. Without it a cycle waits indefinitely.
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int AW         = WB_AW,
  parameter int DW         = WB_DW,
  parameter int WBUF_DEPTH = 4,
  parameter int TMO_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [DW-1:0] req_dat_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          wr_err_o,
  input  logic          wr_err_clr_i,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic [DW/8-1:0] sel_o,
  output logic          we_o,
  output logic          stb_o,
  output logic          cyc_o,
  output logic          tagn_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          err_i
);

  localparam int SW = DW / 8;

  if (TMO_CYCLES < 1) begin : g_bad_tmo
    $error("TMO_CYCLES must be at least 1");
  end
  if ((WBUF_DEPTH < 2) || ((WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("WBUF_DEPTH must be a power of 2 and >= 2");
  end

  // Same field order as wbuf_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } entry_t;

  wb_state_e     state, state_n;
  entry_t        push_ent, head;
  logic          push, pop, full, empty;
  logic          run, rd_pending, accept;
  logic [AW-1:0] rd_adr;
  logic [SW-1:0] rd_sel;
  logic          cyc_end, bus_err, tmo_hit, rd_end;
  logic [AW-1:0] adr_n;
  logic [DW-1:0] dat_n;
  logic [SW-1:0] sel_n;
  logic          we_n, cyc_n;

  // run keeps ready low while reset is asserted and for the first edge after.
  assign req_ready_o = run & ~full & ~rd_pending;
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & req_we_i;
  assign push_ent    = '{adr: req_adr_i, dat: req_dat_i, sel: req_sel_i};

  wb_wbuf_fifo #(.W($bits(entry_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef WB_TIMEOUT_EN
  localparam int TW = (clog2(TMO_CYCLES + 1) < 1) ? 1 : clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Cleared while idle so it starts at 0 on the edge that opens a cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)             tmo_cnt <= '0;
    else if (state == IDLE) tmo_cnt <= '0;
    else if (cyc_o)         tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TMO_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Timeout behaves exactly like err_i; err beats ack when both arrive.
  assign bus_err = err_i | tmo_hit;
  assign cyc_end = (state != IDLE) & (ack_i | bus_err);
  assign pop     = (state == WR_CYC) & cyc_end;
  assign rd_end  = (state == RD_CYC) & cyc_end;

  always_comb begin
    state_n = state;
    cyc_n   = cyc_o;
    we_n    = we_o;
    adr_n   = adr_o;
    dat_n   = dat_o;
    sel_n   = sel_o;
    case (state)
      IDLE: begin
        // Buffered writes drain before the pending read.
        if (!empty) begin
          state_n = WR_CYC;
          cyc_n   = 1'b1;
          we_n    = 1'b1;
          adr_n   = head.adr;
          dat_n   = head.dat;
          sel_n   = head.sel;
        end else if (rd_pending) begin
          state_n = RD_CYC;
          cyc_n   = 1'b1;
          we_n    = 1'b0;
          adr_n   = rd_adr;
          dat_n   = '0;
          sel_n   = rd_sel;
        end
      end
      default: begin
        if (cyc_end) begin
          state_n = IDLE;
          cyc_n   = 1'b0;
          we_n    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cyc_o  <= 1'b0;
      stb_o  <= 1'b0;
      tagn_o <= 1'b0;
      we_o   <= 1'b0;
      adr_o  <= '0;
      dat_o  <= '0;
      sel_o  <= '0;
    end else begin
      state  <= state_n;
      cyc_o  <= cyc_n;
      stb_o  <= cyc_n;
      tagn_o <= cyc_n;
      we_o   <= we_n;
      adr_o  <= adr_n;
      dat_o  <= dat_n;
      sel_o  <= sel_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run         <= 1'b0;
      rd_pending  <= 1'b0;
      rd_adr      <= '0;
      rd_sel      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wr_err_o    <= 1'b0;
    end else begin
      run         <= 1'b1;
      rsp_valid_o <= rd_end;
      // A read can only be accepted with rd_pending low, so these never collide.
      if (accept && !req_we_i) begin
        rd_pending <= 1'b1;
        rd_adr     <= req_adr_i;
        rd_sel     <= req_sel_i;
      end else if (rd_end) begin
        rd_pending <= 1'b0;
      end
      if (rd_end) begin
        rsp_err_o <= bus_err;
        rsp_dat_o <= bus_err ? '0 : dat_i;
      end
      // A new error outranks a clear on the same edge.
      if (pop && bus_err)    wr_err_o <= 1'b1;
      else if (wr_err_clr_i) wr_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: expected bus cycles and read
// responses are queued when a request is accepted and checked when the
// DUT opens a Wishbone cycle or pulses rsp_valid_o.
module tb_wb_master_bridge;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i, req_we_i, wr_err_clr_i;
  logic [AW-1:0] req_adr_i;
  logic [DW-1:0] req_dat_i;
  logic [SW-1:0] req_sel_i;
  logic          req_ready_o, rsp_valid_o, rsp_err_o, wr_err_o;
  logic [DW-1:0] rsp_dat_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic          we_o, stb_o, cyc_o, tagn_o;
  logic [DW-1:0] dat_i;
  logic          ack_i, err_i;

  always #5 clk_i = ~clk_i;

  wb_master_bridge #(.AW(AW), .DW(DW), .WBUF_DEPTH(4), .TMO_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wr_err_o(wr_err_o), .wr_err_clr_i(wr_err_clr_i),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .tagn_o(tagn_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } bus_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  bus_t mon_b;
  rsp_t mon_r;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model: answers after slv_wait wait states unless silent.
  bit            slv_silent = 1'b0, slv_err = 1'b0, slv_both = 1'b0;
  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;

  initial begin
    int wcnt;
    wcnt  = 0;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      ack_i = 1'b0;
      err_i = 1'b0;
      if (cyc_o && stb_o && !slv_silent) begin
        if (wcnt >= slv_wait) begin
          wcnt  = 0;
          dat_i = slv_rdata;
          if (slv_both) begin
            ack_i = 1'b1;
            err_i = 1'b1;
          end else if (slv_err) err_i = 1'b1;
          else ack_i = 1'b1;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitors sample on the falling edge.
  logic prev_cyc = 1'b0, prev_rsp = 1'b0;
  always @(negedge clk_i) begin
    if (cyc_o && !prev_cyc) begin
      chk("bus_exp_avail", exp_bus.size() != 0, 1);
      if (exp_bus.size() != 0) begin
        mon_b = exp_bus.pop_front();
        chk("bus_we", we_o, mon_b.we);
        chk("bus_adr", adr_o, mon_b.adr);
        chk("bus_sel", sel_o, mon_b.sel);
        if (mon_b.we) chk("bus_dat", dat_o, mon_b.dat);
      end
    end
    if (cyc_o) chk("bus_stb_tagn", {stb_o, tagn_o}, 2'b11);
    if (rsp_valid_o) begin
      chk("rsp_exp_avail", exp_rsp.size() != 0, 1);
      chk("rsp_pulse", prev_rsp, 0);
      if (exp_rsp.size() != 0) begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_dat", rsp_dat_o, mon_r.dat);
        chk("rsp_err", rsp_err_o, mon_r.err);
      end
    end
    prev_cyc <= cyc_o;
    prev_rsp <= rsp_valid_o;
  end

  task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input rsp_t er);
    int   n;
    bus_t b;
    n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_sel_i   = sel;
    while (!req_ready_o && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("accept_in_time", n < 100, 1);
    if (n < 100) begin
      b.we = we; b.adr = adr; b.dat = dat; b.sel = sel;
      exp_bus.push_back(b);
      if (!we) exp_rsp.push_back(er);
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0 || cyc_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, n < 300, 1);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] sels [4];
    int            n;
    sels = '{4'hF, 4'h1, 4'h3, 4'hC};
    req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0;
    req_dat_i = '0; req_sel_i = '0; wr_err_clr_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_bus", {cyc_o, stb_o, we_o, tagn_o}, 4'b0);
    chk("rst_adr", adr_o, 0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, wr_err_o}, 3'b0);
    chk("rst_ready", req_ready_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ready_after_rst", req_ready_o, 1);

    // 1: read with 3 wait states
    slv_wait = 3; slv_rdata = 32'hDEADBEEF;
    send(1'b0, 26'h0000100, '0, 4'hF, '{1'b0, 32'hDEADBEEF});
    @(negedge clk_i); chk("t1_cyc_accept_cycle", cyc_o, 0);
    @(negedge clk_i); chk("t1_cyc_next_cycle", cyc_o, 1);
    wait_idle("t1_done");

    // 2: four back-to-back writes against a stalled slave
    slv_silent = 1'b1; slv_wait = 0;
    for (int i = 0; i < 4; i++)
      send(1'b1, 26'h200 + 26'(4 * i), 32'hA0 + 32'(i), sels[i], '{1'b0, 32'h0});
    chk("t2_full_ready", req_ready_o, 0);
    slv_silent = 1'b0;
    wait_idle("t2_done");

    // 3: write then read; read must wait for the write and block accepts
    slv_wait = 5; slv_rdata = 32'h12345678;
    send(1'b1, 26'h10, 32'h55AA, 4'hF, '{1'b0, 32'h0});
    send(1'b0, 26'h10, '0, 4'hF, '{1'b0, 32'h12345678});
    chk("t3_pend_ready", req_ready_o, 0);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 26'h3FC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("t3_no_accept", req_ready_o, 0);
    end
    req_valid_i = 1'b0;
    wait_idle("t3_done");

    // 4: ack+err together on a read; err on a posted write
    slv_wait = 1; slv_both = 1'b1; slv_rdata = 32'hFFFF0000;
    send(1'b0, 26'h20, '0, 4'h3, '{1'b1, 32'h0});
    wait_idle("t4_rd_done");
    slv_both = 1'b0; slv_err = 1'b1;
    send(1'b1, 26'h24, 32'h77, 4'hF, '{1'b0, 32'h0});
    wait_idle("t4_wr_done");
    slv_err = 1'b0;
    chk("t4_wr_err", wr_err_o, 1);
    repeat (3) @(negedge clk_i);
    chk("t4_wr_err_sticky", wr_err_o, 1);
    wr_err_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    wr_err_clr_i = 1'b0;
    chk("t4_wr_err_clr", wr_err_o, 0);

    // 5: silent slave
    slv_silent = 1'b1; slv_wait = 0; slv_rdata = 32'hCAFEF00D;
`ifdef WB_TIMEOUT_EN
    send(1'b0, 26'h30, '0, 4'hF, '{1'b1, 32'h0});
    @(negedge clk_i);
    @(negedge clk_i);
    n = 0;
    while (cyc_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    chk("t5_tmo_len", n, 8);
    wait_idle("t5_done");
    slv_silent = 1'b0;
`else
    send(1'b0, 26'h30, '0, 4'hF, '{1'b0, 32'hCAFEF00D});
    repeat (30) @(negedge clk_i);
    chk("t5_cyc_held", cyc_o, 1);
    slv_silent = 1'b0;
    wait_idle("t5_done");
`endif

    // 6: reset in the middle of traffic with writes buffered and a read pending
    slv_silent = 1'b1;
    send(1'b1, 26'h40, 32'h1, 4'hF, '{1'b0, 32'h0});
    send(1'b1, 26'h44, 32'h2, 4'hF, '{1'b0, 32'h0});
    send(1'b0, 26'h48, '0, 4'hF, '{1'b0, 32'h0});
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t6_cyc_before", cyc_o, 1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_rst_bus", {cyc_o, stb_o, we_o, tagn_o}, 4'b0);
    chk("t6_rst_adr", adr_o, 0);
    exp_bus.delete();
    exp_rsp.delete();
    slv_silent = 1'b0;
    #3;
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("t6_no_cyc", cyc_o, 0);
    chk("t6_ready", req_ready_o, 1);

    chk("end_bus_q", exp_bus.size(), 0);
    chk("end_rsp_q", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
